// File: rtl/gray_seq_ctrl.sv
// Gray-code step sequencer: runs a programmable number of up/down Gray steps
// with pause (hold), abort and one-cycle done/wrap pulses.
module gray_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir,
    input  logic [CW-1:0]    steps,
    input  logic             hold,
    input  logic             abort,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             wrap,
    output logic [CW-1:0]    remaining
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        DONE
    } state_t;

    localparam logic [WIDTH-1:0] B_ONE = WIDTH'(1);
    localparam logic [CW-1:0]    R_ONE = CW'(1);

    state_t           state;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] b_nxt;
    logic [WIDTH-1:0] g_nxt;
    logic             dir_q;
    logic             wrap_nxt;

    always_comb begin
        b_nxt    = dir_q ? (b - B_ONE) : (b + B_ONE);
        g_nxt    = b_nxt ^ (b_nxt >> 1);
        // wrap-around is the step leaving the all-ones/all-zeros end
        wrap_nxt = dir_q ? (b == '0) : (b == '1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            b         <= '0;
            q         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wrap      <= 1'b0;
            remaining <= '0;
            dir_q     <= 1'b0;
        end else begin
            done <= 1'b0;
            wrap <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (steps != '0) begin
                            state     <= RUN;
                            busy      <= 1'b1;
                            dir_q     <= dir;
                            remaining <= steps;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        remaining <= '0;
                    end else if (hold) begin
                        state <= PAUSE;
                    end else begin
                        b         <= b_nxt;
                        q         <= g_nxt;
                        wrap      <= wrap_nxt;
                        remaining <= remaining - R_ONE;
                        if (remaining == R_ONE) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                PAUSE: begin
                    if (abort) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        remaining <= '0;
                    end else if (!hold) begin
                        state <= RUN;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Directed testbench for gray_seq_ctrl with hand-computed Gray sequences.
module tb_gray_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       dir;
    logic [7:0] steps;
    logic       hold;
    logic       abort;
    logic [3:0] q;
    logic       busy;
    logic       done;
    logic       wrap;
    logic [7:0] remaining;

    int checks = 0;
    int errors = 0;

    logic [3:0] up_q [17] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                              4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8,
                              4'h0};

    gray_seq_ctrl #(.WIDTH(4), .CW(8)) dut (
        .clk(clk), .rst(rst), .start(start), .dir(dir), .steps(steps),
        .hold(hold), .abort(abort), .q(q), .busy(busy), .done(done),
        .wrap(wrap), .remaining(remaining)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    int busy_cnt;
    int done_cnt;
    int wrap_cnt;
    int elapsed;

    initial begin
        rst = 1'b1; start = 1'b0; dir = 1'b0; steps = '0;
        hold = 1'b0; abort = 1'b0;
        do_reset();
        chk("rst_q", q, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_rem", remaining, 0);

        // full up run of 16 steps
        start = 1'b1; dir = 1'b0; steps = 8'd16;
        tick();
        start = 1'b0;
        chk("up_acc_rem", remaining, 16);
        chk("up_acc_q", q, 0);
        busy_cnt = busy ? 1 : 0;
        done_cnt = 0; wrap_cnt = 0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk($sformatf("up_q%0d", i), q, up_q[i]);
            chk($sformatf("up_rem%0d", i), remaining, 16 - i);
            chk($sformatf("up_wrap%0d", i), wrap, (i == 16));
            busy_cnt += busy ? 1 : 0;
            done_cnt += done ? 1 : 0;
            wrap_cnt += wrap ? 1 : 0;
        end
        tick();
        done_cnt += done ? 1 : 0;
        chk("up_busy_cycles", busy_cnt, 16);
        chk("up_done_pulses", done_cnt, 1);
        chk("up_wrap_pulses", wrap_cnt, 1);
        chk("up_idle_busy", busy, 0);

        // down run of 3 steps from 0000
        start = 1'b1; dir = 1'b1; steps = 8'd3;
        tick();
        start = 1'b0; dir = 1'b0;
        chk("dn_rem0", remaining, 3);
        tick();
        chk("dn_q1", q, 4'h8);
        chk("dn_wrap1", wrap, 1);
        chk("dn_rem1", remaining, 2);
        tick();
        chk("dn_q2", q, 4'h9);
        chk("dn_wrap2", wrap, 0);
        chk("dn_rem2", remaining, 1);
        tick();
        chk("dn_q3", q, 4'hB);
        chk("dn_rem3", remaining, 0);
        chk("dn_done", done, 1);
        tick();
        chk("dn_done_end", done, 0);

        // zero-step run
        start = 1'b1; steps = 8'd0;
        tick();
        start = 1'b0;
        chk("z_done", done, 1);
        chk("z_busy", busy, 0);
        chk("z_q", q, 4'hB);
        tick();
        chk("z_done_end", done, 0);
        chk("z_busy2", busy, 0);
        chk("z_q2", q, 4'hB);

        // hold mid-run: 6 steps, hold 3 cycles after step 2
        do_reset();
        start = 1'b1; dir = 1'b0; steps = 8'd6;
        tick();
        start = 1'b0;
        elapsed = 0;
        tick(); elapsed++;
        tick(); elapsed++;
        chk("h_q2", q, 4'h3);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); elapsed++;
            chk($sformatf("h_frz_q%0d", i), q, 4'h3);
            chk($sformatf("h_frz_rem%0d", i), remaining, 4);
            chk($sformatf("h_frz_busy%0d", i), busy, 1);
        end
        hold = 1'b0;
        tick(); elapsed++;
        chk("h_resume_q", q, 4'h3);
        chk("h_resume_rem", remaining, 4);
        for (int i = 3; i <= 6; i++) begin
            tick(); elapsed++;
            chk($sformatf("h_q%0d", i), q, up_q[i]);
        end
        chk("h_done", done, 1);
        chk("h_latency", elapsed, 10);
        tick();

        // abort after 5 up steps
        do_reset();
        start = 1'b1; dir = 1'b0; steps = 8'd10;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("a_q5", q, 4'h7);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("a_q", q, 4'h7);
        chk("a_busy", busy, 0);
        chk("a_rem", remaining, 0);
        chk("a_done", done, 0);
        tick();
        chk("a_done2", done, 0);
        chk("a_q_hold", q, 4'h7);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("a_idle_q", q, 4'h7);
        chk("a_idle_done", done, 0);
        start = 1'b1; steps = 8'd1;
        tick();
        start = 1'b0;
        chk("a_restart_busy", busy, 1);
        chk("a_restart_rem", remaining, 1);
        tick();
        chk("a_restart_q", q, 4'h5);
        chk("a_restart_done", done, 1);
        tick();

        // reset mid-run with start asserted
        start = 1'b1; steps = 8'd5;
        tick();
        start = 1'b0;
        tick();
        chk("r_q1", q, 4'h4);
        rst = 1'b1; start = 1'b1; steps = 8'd3;
        tick();
        rst = 1'b0; start = 1'b0;
        chk("r_q", q, 0);
        chk("r_busy", busy, 0);
        chk("r_rem", remaining, 0);
        chk("r_done", done, 0);
        tick();
        chk("r_busy2", busy, 0);
        chk("r_q2", q, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
